// File: rtl/keccak_arbiter.sv
// Round-robin owner arbitration for one shared Keccak core, with a reset-held
// drain gap between owners and an optional watchdog on grant length.
module keccak_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned IDW       = 2,
    parameter int unsigned DRAIN_CYC = 2,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      rel,
    output logic [NREQ-1:0]      grant,
    input  logic [NREQ-1:0]      rq_rst_k,
    input  logic [64*NREQ-1:0]   rq_din,
    input  logic [NREQ-1:0]      rq_src_ready,
    input  logic [NREQ-1:0]      rq_dst_ready,
    output logic [NREQ-1:0]      rq_src_read,
    output logic [NREQ-1:0]      rq_dst_write,
    output logic [63:0]          rq_dout,
    output logic                 rst_k,
    output logic [63:0]          din,
    output logic                 src_ready,
    output logic                 dst_ready,
    input  logic                 src_read,
    input  logic                 dst_write,
    input  logic [63:0]          dout,
    output logic [IDW-1:0]       owner,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned HOLD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned DRN_W  = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              terr_q, terr_d;

    logic              win_found;
    logic [IDW-1:0]    win_idx;
    int unsigned       cand;
    logic              rel_hit;
    logic              timeout_hit;
    logic [IDW-1:0]    owner_succ;

    // First requesting lane searching upward from the round-robin pointer
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(rr_q) + i) % NREQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    assign rel_hit     = |(rel & grant_q);
    assign timeout_hit = (TIMEOUT != 0) && (hold_q == HOLD_W'(TIMEOUT - 1));
    assign owner_succ  = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + IDW'(1);

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            drain_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            drain_q <= drain_d;
            terr_q  <= terr_d;
        end
    end

    // Next-state: arbitrate in IDLE, watch release/watchdog in BUSY, count down DRAIN
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        drain_d = drain_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    grant_d = NREQ'(1) << win_idx;
                    hold_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                hold_d = (&hold_q) ? hold_q : hold_q + HOLD_W'(1);
                if (rel_hit || timeout_hit) begin
                    grant_d = '0;
                    rr_d    = owner_succ;
                    drain_d = DRN_W'(DRAIN_CYC - 1);
                    terr_d  = !rel_hit;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Core-side mux from the owner while BUSY; core held in reset otherwise
    always_comb begin
        rst_k     = 1'b1;
        din       = '0;
        src_ready = 1'b0;
        dst_ready = 1'b0;
        if (state_q == BUSY) begin
            rst_k     = rq_rst_k[owner_q];
            din       = rq_din[{owner_q, 6'd0} +: 64];
            src_ready = rq_src_ready[owner_q];
            dst_ready = rq_dst_ready[owner_q];
        end
    end

    assign rq_src_read  = {NREQ{src_read}} & grant_q;
    assign rq_dst_write = {NREQ{dst_write}} & grant_q;
    assign rq_dout      = dout;

    assign grant       = grant_q;
    assign owner       = owner_q;
    assign busy        = (state_q == BUSY);
    assign timeout_err = terr_q;

endmodule

// File: doc/keccak_arbiter.md
Name: keccak_arbiter

Overview:
- Shares the single Keccak core among NREQ sampler/hash requesters, e.g. sampler_s, the uniform sampler and the challenge sampler.
- Grants the core round-robin. While a requester owns the core, its Keccak passthrough bus (rst_k, din, src_ready, dst_ready, src_read, dst_write) is routed to the core.
- Between owners, the core is held in reset for a drain period.
- A watchdog forcibly reclaims the core from an owner that holds it too long.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of owner index (clog2 NREQ, min 1).
- DRAIN_CYC, 2, cycles core rst_k is held high after a release (>=1).
- TIMEOUT, 0, max cycles one grant may last; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- rel  in  NREQ  per-requester release pulse (requester done).
- grant  out  NREQ  one-hot keccak_ctrl to each requester; at most one bit high.
- rq_rst_k  in  NREQ  each requester's rst_k.
- rq_din  in  64*NREQ  each requester's din; lane i is bits [64i+63:64i].
- rq_src_ready  in  NREQ  each requester's src_ready.
- rq_dst_ready  in  NREQ  each requester's dst_ready.
- rq_src_read  out  NREQ  core src_read demuxed to the owner.
- rq_dst_write  out  NREQ  core dst_write demuxed to the owner.
- rq_dout  out  64  core dout broadcast to all requesters.
- rst_k  out  1  core reset.
- din  out  64  core data in.
- src_ready  out  1  core source-ready.
- dst_ready  out  1  core sink-ready.
- src_read  in  1  from core.
- dst_write  in  1  from core.
- dout  in  64  from core.
- owner  out  IDW  index of the current owner.
- busy  out  1  high in BUSY.
- timeout_err  out  1  one-cycle pulse on a forced reclaim.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, grant=0, owner=0, rr_ptr=0, busy=0, timeout_err=0.
  - Core rst_k=1; din=0, src_ready=0, dst_ready=0.
  - drain_ctr=0, hold_ctr=0.
  - Reset may occur mid-grant; there is no handoff and all outputs return to reset values immediately.
- States: IDLE, BUSY, DRAIN. All transitions occur on the rising edge of clk.
- IDLE:
  - Core rst_k=1; din, src_ready and dst_ready=0; all rq_src_read and rq_dst_write=0.
  - If any req bit is high, the winner is the first set bit searching upward from rr_ptr, wrapping at NREQ-1 to 0.
  - Next edge: owner<=winner, grant<=onehot(winner), hold_ctr<=0, state->BUSY.
  - Latency: req sampled high at edge t gives grant high after edge t+1, i.e. 1 cycle.
- BUSY (registered grant, combinational routing):
  - Core outputs: rst_k=rq_rst_k[owner], din=rq_din lane owner, src_ready=rq_src_ready[owner], dst_ready=rq_dst_ready[owner].
  - Demux: rq_src_read[owner]=src_read and rq_dst_write[owner]=dst_write; all other lanes are 0.
  - hold_ctr increments each cycle and saturates.
  - Release: rel[owner]=1 causes grant<=0, rr_ptr<=owner+1 (mod NREQ), drain_ctr<=DRAIN_CYC-1, state->DRAIN.
  - rel on a non-owner lane is ignored.
  - Deasserting req[owner] is not a release; the grant persists.
  - Timeout: if TIMEOUT!=0 and hold_ctr==TIMEOUT-1 without a release, the arbiter does the same transition as a release and pulses timeout_err for 1 cycle.
  - rel and timeout in the same cycle count as a release; no error pulse.
- DRAIN:
  - Same core outputs as IDLE (rst_k=1).
  - drain_ctr decrements; when it reaches 0, state->IDLE.
  - New requests wait. The just-released requester has lowest priority in the next arbitration.
- owner holds its last value outside BUSY.
- busy = (state==BUSY).
- rq_dout = dout always, independent of state.
- Invariant: grant is one-hot or zero, and nonzero only in BUSY.

Test Plan:
- Single requester, NREQ=4, DRAIN_CYC=2: req=0001 at cycle 0 -> grant=0001 from cycle 1. Drive rq_din lane0=64'hE00f000000000210 -> din matches. Pulse rel[0] at cycle 10 -> grant=0 at cycle 11, rst_k=1 for cycles 11-12, IDLE at cycle 13.
- Round-robin: req=1111 held, each owner releases after 5 cycles -> grant order 0001, 0010, 0100, 1000, 0001.
- Isolation: owner=2, core src_read=1, dst_write=1 -> rq_src_read=0100, rq_dst_write=0100. rel[0] pulse -> ignored, grant stays 0100.
- Watchdog, TIMEOUT=8: owner never releases -> timeout_err pulses at 8 cycles after grant, grant=0, next requester granted after drain.
- Simultaneous: rel[1] with req=0011 -> requester 0 wins the next grant (rr_ptr=2 wraps to 0).
- Async reset mid-BUSY: rst_n low between clock edges -> grant=0, rst_k=1, busy=0 immediately. After release, req=0100 -> grant=0100 one cycle later (rr_ptr=0 search).
